// File: rtl/prog_loader.sv
// Boot loader: streams instruction words into imem, holds the CPU in reset, then releases it.
// Define PROG_LOADER_CLEAR_EN to NOP-fill the unused tail of imem after the last word.
module prog_loader #(
    parameter int IW             = 13,
    parameter int AW             = 5,
    parameter int DEPTH          = 32,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          err_overflow,
    output logic [AW:0]   word_count
);

    localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
    localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);
    localparam logic [3:0]    RelLoad   = 4'(RELEASE_CYCLES);

`ifdef PROG_LOADER_CLEAR_EN
    typedef enum logic [2:0] {Idle, Load, Drain, Fill, Release, Run} state_t;
`else
    typedef enum logic [2:0] {Idle, Load, Drain, Release, Run} state_t;
`endif

    state_t        state;
    logic [AW-1:0] ptr;
    logic [3:0]    relCnt;
    logic          accept;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= Idle;
            ptr          <= '0;
            relCnt       <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                Idle: begin
                    if (start) begin
                        state        <= Load;
                        in_ready     <= 1'b1;
                        ptr          <= '0;
                        word_count   <= '0;
                        err_overflow <= 1'b0;
                        done         <= 1'b0;
                    end
                end
                Load: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= in_data;
                        ptr        <= ptr + 1'b1;
                        if (word_count != FullCount)
                            word_count <= word_count + 1'b1;
                        if (in_last) begin
                            in_ready <= 1'b0;
`ifdef PROG_LOADER_CLEAR_EN
                            if (ptr != LastAddr) begin
                                state <= Fill;
                            end else begin
                                state  <= Release;
                                relCnt <= RelLoad;
                            end
`else
                            state  <= Release;
                            relCnt <= RelLoad;
`endif
                        end else if (ptr == LastAddr) begin
                            // Memory full but stream continues: swallow the rest.
                            state        <= Drain;
                            err_overflow <= 1'b1;
                        end
                    end
                end
                Drain: begin
                    if (accept && in_last) begin
                        state    <= Release;
                        in_ready <= 1'b0;
                        relCnt   <= RelLoad;
                    end
                end
`ifdef PROG_LOADER_CLEAR_EN
                Fill: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= '0;
                    ptr        <= ptr + 1'b1;
                    if (ptr == LastAddr) begin
                        state  <= Release;
                        relCnt <= RelLoad;
                    end
                end
`endif
                Release: begin
                    if (relCnt == 4'd1) begin
                        state     <= Run;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        relCnt <= relCnt - 4'd1;
                    end
                end
                Run: begin
                    if (start) begin
                        state        <= Load;
                        in_ready     <= 1'b1;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        ptr          <= '0;
                        word_count   <= '0;
                        err_overflow <= 1'b0;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the processor's instruction unit.
- Accepts a valid/ready stream of 13-bit instruction words and writes them sequentially into the 32-entry instruction memory.
- Holds the processor in reset while loading, then releases it.
- Reports word count, completion and overflow status.

Parameters:
IW, 13, instruction word width (matches IR width)
AW, 5, instruction memory address width (matches PC width)
DEPTH, 32, number of instruction memory entries; must equal 2**AW
RELEASE_CYCLES, 2, cycles cpu_reset stays high after the final write before release; must be 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse that begins a (re)load
in_valid  input  1  stream word valid
in_data  input  IW  stream instruction word
in_last  input  1  marks final word of program, qualified by in_valid
in_ready  output  1  loader can accept a stream word this cycle
imem_we  output  1  instruction memory write strobe
imem_addr  output  AW  instruction memory write address
imem_wdata  output  IW  instruction memory write data
cpu_reset  output  1  active-high reset to processor; high while loading
done  output  1  program loaded and processor running
err_overflow  output  1  stream exceeded DEPTH words; sticky until next start
word_count  output  AW+1  number of words written in the current/last load (0..DEPTH)

Behaviour:
- Reset (reset low, async): state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, err_overflow=0, word_count=0, internal write pointer ptr=0.
- All outputs are registered. An accept is in_valid & in_ready at a rising edge.
- States: IDLE, LOAD, DRAIN, FILL (only with the optional feature), RELEASE, RUN.
- IDLE:
  - in_ready=0, cpu_reset=1.
  - start -> LOAD; ptr=0, word_count=0, err_overflow=0, done=0.
- LOAD:
  - in_ready=1.
  - On accept: next cycle imem_we=1, imem_addr=ptr, imem_wdata=in_data (1-cycle write latency); ptr and word_count increment.
  - imem_we=0 on cycles with no accept.
  - Accept with in_last=1 -> FILL if the feature is enabled and ptr<DEPTH-1; otherwise RELEASE.
  - Accept at ptr==DEPTH-1 with in_last=0 -> DRAIN; that word is still written.
  - in_last on a word written at ptr==DEPTH-1 is a normal completion with no overflow.
- DRAIN:
  - err_overflow=1, in_ready=1, no writes.
  - Beats are discarded until an accept with in_last=1, then -> RELEASE.
  - word_count stays DEPTH.
- RELEASE:
  - in_ready=0, cpu_reset=1, imem_we=0 after the final write.
  - A down-counter runs RELEASE_CYCLES cycles. On expiry cpu_reset=0 and done=1 (same edge) -> RUN.
- RUN:
  - cpu_reset=0, done=1, in_ready=0.
  - start -> LOAD: cpu_reset=1 and done=0 on the next edge; ptr=0, word_count=0, err_overflow=0.
- start is ignored in LOAD, DRAIN, FILL and RELEASE.
- Empty program: not possible; in_last always accompanies a real word.
- in_data and in_last are don't-care when in_valid=0.
- Reset asserted mid-load aborts immediately to reset values. Memory contents are left partially written; a fresh start is required.
- ptr wraps are never exercised: LOAD exits at DEPTH-1.
- word_count saturates at DEPTH.

Optional Feature:
- Macro: PROG_LOADER_CLEAR_EN.
- Defined:
  - After in_last at ptr<DEPTH-1, enter FILL, one write per cycle: imem_we=1, imem_wdata=0 (NOP), imem_addr=ptr..DEPTH-1.
  - in_ready=0 during FILL.
  - word_count does not count fill writes.
  - After writing address DEPTH-1 -> RELEASE.
- Not defined: FILL state is absent; LOAD goes straight to RELEASE and unused memory keeps its prior contents.

Test Plan:
- Reset low, then high with no start -> all outputs at reset values, cpu_reset=1 indefinitely.
- start; stream 3 words 0x0001, 0x1ABC, 0x0FFF (last on third), in_valid continuous; feature off:
  - imem_we pulses at addrs 0,1,2 with matching data, one cycle after each accept.
  - cpu_reset falls 2 cycles after the last write; done=1; word_count=3.
- Same stream with in_valid toggling 1,0,1,0,1 -> writes only on accepted beats, addresses contiguous 0..2, same final status.
- 34-word stream, last on word 34:
  - addrs 0..31 written, words 33–34 discarded.
  - err_overflow=1, word_count=32, then release.
- PROG_LOADER_CLEAR_EN defined, 2-word program:
  - writes data at addrs 0..1, then 0x0000 at addrs 2..31 on 30 consecutive cycles.
  - then release; word_count=2.
- In RUN, pulse start; mid-load drop reset:
  - cpu_reset=1 next edge after start.
  - after reset all outputs return to reset values; a new start reloads from addr 0.
